fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder (ctrl).
- Owns the PC register and issues word requests to instruction memory over a valid/ready request and valid response interface.
- Buffers one fetched instruction and presents it with pre-split op/funct3/funct7 fields to ctrl and the datapath.
- Applies the pcSrc/PCTarget redirect when the consuming stage accepts the current instruction.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value held on Instr when no instruction is valid (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  Instr/PC valid to decode.
- instr_ready  in  1  decode consumes instruction.
- Instr  out  32  buffered instruction.
- PC  out  XLEN  address of Instr.
- PCPlus4  out  XLEN  PC + 4.
- op  out  7  Instr[6:0].
- funct3  out  3  Instr[14:12].
- funct7  out  1  Instr[30].
- pcSrc  in  1  take redirect, from ctrl.
- PCTarget  in  XLEN  redirect target from datapath.
- fetch_fault  out  1  misaligned-target trap; only present with the optional feature.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high, sampled on rising edge.
- Reset values:
  - State = IDLE; fetch_pc = RESET_VECTOR.
  - imem_req_valid = 0; imem_addr = RESET_VECTOR.
  - instr_valid = 0; Instr = NOP_INSTR; PC = RESET_VECTOR; PCPlus4 = RESET_VECTOR + 4.
  - fetch_fault = 0.
- FSM states: IDLE, REQ, WAIT, FULL.
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_valid = 1, imem_addr = fetch_pc, both held stable until accepted. imem_req_valid & imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, register Instr = imem_rsp_data and PC = fetch_pc; set instr_valid = 1 next cycle -> FULL.
  - FULL: instr_valid = 1, and Instr/PC/fields are held stable.
    - On instr_valid & instr_ready: clear instr_valid and set Instr = NOP_INSTR.
    - Next fetch_pc = pcSrc ? PCTarget : PC + 4 -> REQ.
- Exactly one outstanding request. imem_rsp_valid is ignored in IDLE, REQ and FULL, so a stale response after a mid-WAIT reset is dropped.
- pcSrc and PCTarget are sampled only in the consume cycle; they are don't-care otherwise.
- Minimum latency with zero-wait memory (req_ready = 1, rsp one cycle after accept): 3 cycles from request to instr_valid, and 1 request per 3 cycles plus decode stall cycles.
- op/funct3/funct7 are combinational slices of the Instr register. They are therefore NOP fields (0010011, 000, 0) when invalid.
- PCPlus4 wraps modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
- Reset in any state overrides all other events in the same cycle.
- imem_addr[1:0] is always forced to 00.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - A redirect with PCTarget[1:0] != 00 issues no request; the FSM enters FULL with Instr = NOP_INSTR, PC = PCTarget and fetch_fault = 1.
  - fetch_fault clears on consume or reset.
- Disabled:
  - The fetch_fault port is absent.
  - PCTarget[1:0] is silently dropped (target rounded down).

Decomposition:
- Package fetch_pkg:
  - fetch_state_e enum (IDLE, REQ, WAIT, FULL).
  - XLEN default, RESET_VECTOR default, NOP_INSTR, opcode constants (OP_LW, OP_SW, OP_JAL, OP_BEQ, OP_ITYPE, OP_RTYPE), shared with ctrl.
- Sub-module next_pc_mux: combinational PC + 4 / PCTarget select plus alignment check. Natural to reuse in the datapath.

Test Plan:
- Reset, then zero-wait memory returning 0x00A00093 at address 0:
  - imem_addr = 0 in the first REQ cycle.
  - instr_valid after 3 cycles with PC = 0, op = 0010011, funct3 = 000.
- instr_ready held 0 for 5 cycles:
  - Instr/PC stable, no new imem_req_valid.
  - After ready, the next imem_addr = 4.
- Consume with pcSrc = 1, PCTarget = 0x40: next imem_addr = 0x40, and the returned word appears with PC = 0x40.
- imem_req_ready low 4 cycles and imem_rsp_valid delayed 3 cycles:
  - imem_addr stable throughout.
  - A spurious rsp_valid during REQ is ignored, and only the WAIT response is captured.
- Assert rst during WAIT, then deliver the old response:
  - The response is dropped.
  - Fetch restarts at RESET_VECTOR, with instr_valid = 0 and Instr = 0x00000013.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x42:
  - No request is issued.
  - fetch_fault = 1, PC = 0x42, Instr = NOP_INSTR.
  - Without the macro: imem_addr = 0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also used by the ctrl decoder.
package fetch_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: sequential PC + 4 or taken redirect target, plus a
// flag for a redirect target that is not word aligned.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_target,
    input  logic            pc_src,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    assign pc_plus4   = pc + XLEN'(4);
    assign next_pc    = pc_src ? pc_target : pc_plus4;
    assign misaligned = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, one
// buffered instruction. FETCH_MISALIGN_TRAP_EN adds the fetch_fault trap.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0]     NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] PCTarget
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-3:0] fetch_word;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            capture, consume, trap;
    logic            unused_bits;

    next_pc_mux #(.XLEN(XLEN)) u_next_pc (
        .pc         (pc_q),
        .pc_target  (PCTarget),
        .pc_src     (pcSrc),
        .pc_plus4   (PCPlus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap        = misaligned;
    assign unused_bits = ^next_pc[1:0];
`else
    // Misaligned redirect targets are simply rounded down to a word.
    assign trap        = 1'b0;
    assign unused_bits = ^{misaligned, next_pc[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        capture        = 1'b0;
        consume        = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nxt = WAIT;
            end
            // Responses outside WAIT are stale or spurious and never captured.
            WAIT: begin
                if (imem_rsp_valid) begin
                    capture   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (instr_ready) begin
                    consume   = 1'b1;
                    state_nxt = trap ? FULL : REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The fetch address is kept as a word index so imem_addr[1:0] is always 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_word <= RESET_VECTOR[XLEN-1:2];
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_VECTOR;
        end else begin
            if (capture) begin
                instr_q <= imem_rsp_data;
                pc_q    <= {fetch_word, 2'b00};
            end
            if (consume) begin
                instr_q <= NOP_INSTR;
                if (trap) pc_q <= PCTarget;
                else      fetch_word <= next_pc[XLEN-1:2];
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)          fetch_fault <= 1'b0;
        else if (consume) fetch_fault <= trap;
    end
`endif

    assign imem_addr   = {fetch_word, 2'b00};
    assign instr_valid = (state == FULL);
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory/decode behaviour checked
// against a fetch-address and instruction-order reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] WORD0 = 32'h00A0_0093;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] Instr, PC, PCPlus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        pcSrc;
    logic [31:0] PCTarget;
    logic        fetch_fault;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .pcSrc          (pcSrc),
        .PCTarget       (PCTarget)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] exp_addr;
    int          checks, errors;

    // stimulus knobs
    int ready_pct, rsp_min, rsp_max, cons_pct, redir_pct;
    bit spurious_en, auto_cons;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return $urandom & 32'hFFFF_FFFC;
            1:       return ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            2:       return 32'hFFFF_FFFC;
            default: return 32'h100 + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    // Instruction memory: single outstanding request, configurable latency.
    initial begin : memory
        bit          pend;
        int          cnt;
        logic [31:0] pend_data;
        pend = 0; cnt = 0; pend_data = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend_data;
                    pend = 0;
                end else cnt--;
            end else if (spurious_en) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            imem_req_ready = !pend && ($urandom_range(1, 100) <= ready_pct);
            if (!rst) begin
                chk("req_during_full", 32'(imem_req_valid & instr_valid), 32'd0);
                if (imem_req_valid) chk("imem_addr", imem_addr, exp_addr);
                if (imem_req_valid && imem_req_ready) begin
                    pend_data = (exp_addr == 32'd0) ? WORD0 : $urandom;
                    expq.push_back('{exp_addr, pend_data, 1'b0});
                    pend = 1;
                    cnt  = $urandom_range(rsp_min, rsp_max);
                end
            end
        end
    end

    // Random decode consumer.
    initial begin : consumer
        forever begin
            @(negedge clk);
            if (auto_cons) begin
                instr_ready = ($urandom_range(1, 100) <= cons_pct);
                pcSrc       = instr_ready && ($urandom_range(1, 100) <= redir_pct);
                PCTarget    = pick_target();
            end
        end
    end

    // Monitor: pops one expectation per presented instruction, updates model on consume.
    initial begin : monitor
        exp_t cur;
        bit   presented, have_cur, trap_hit;
        presented = 0; have_cur = 0; exp_addr = 32'h0;
        cur = '{32'h0, NOP, 1'b0};
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                expq.delete();
                exp_addr  = 32'h0;
                presented = 0;
                have_cur  = 0;
            end else if (instr_valid) begin
                if (!presented) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_instr actual PC=%h required no instruction", PC);
                        have_cur = 0;
                    end else begin
                        cur = expq.pop_front();
                        have_cur = 1;
                    end
                    presented = 1;
                end
                if (have_cur) begin
                    chk("instr",   Instr,   cur.instr);
                    chk("pc",      PC,      cur.pc);
                    chk("pcplus4", PCPlus4, cur.pc + 32'd4);
                    chk("op",      32'(op),     32'(cur.instr[6:0]));
                    chk("funct3",  32'(funct3), 32'(cur.instr[14:12]));
                    chk("funct7",  32'(funct7), 32'(cur.instr[30]));
                    chk("fault",   32'(fetch_fault), 32'(cur.fault));
                end
                if (instr_ready) begin
                    presented = 0;
                    if (have_cur) begin
                        trap_hit = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        trap_hit = pcSrc && (PCTarget[1:0] != 2'b00);
`endif
                        if (trap_hit) expq.push_back('{PCTarget, NOP, 1'b1});
                        else exp_addr = pcSrc ? (PCTarget & 32'hFFFF_FFFC)
                                              : ((cur.pc + 32'd4) & 32'hFFFF_FFFC);
                    end
                    have_cur = 0;
                end
            end else begin
                presented = 0;
                chk("nop_when_invalid", Instr, NOP);
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 60; i++) begin
            if (instr_valid) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL %s actual=no instr_valid required=instr_valid within 60 cycles", name);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 60; i++) begin
            if (imem_req_valid) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL %s actual=no imem_req_valid required=request within 60 cycles", name);
    endtask

    task automatic consume(input bit src, input logic [31:0] tgt);
        instr_ready = 1'b1;
        pcSrc       = src;
        PCTarget    = tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        pcSrc       = 1'b0;
        PCTarget    = $urandom;
    endtask

    initial begin : main
        checks = 0; errors = 0;
        rst = 1'b1;
        instr_ready = 0; pcSrc = 0; PCTarget = 0;
        ready_pct = 100; rsp_min = 0; rsp_max = 0;
        cons_pct = 0; redir_pct = 0; spurious_en = 0; auto_cons = 0;
        do_reset(3);

        // reset state (IDLE cycle after release)
        chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
        chk("rst_imem_addr",   imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr",       Instr, NOP);
        chk("rst_pc",          PC, 32'h0);
        chk("rst_pcplus4",     PCPlus4, 32'h4);
        chk("rst_op",          32'(op), 32'h13);
        chk("rst_funct3",      32'(funct3), 32'd0);
        chk("rst_fault",       32'(fetch_fault), 32'd0);

        // zero-wait first fetch: REQ, WAIT, then valid
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr",  imem_addr, 32'h0);
        @(negedge clk);
        chk("latency_wait",    32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid",   32'(instr_valid), 32'd1);
        chk("first_pc",        PC, 32'h0);
        chk("first_op",        32'(op), 32'b0010011);
        chk("first_funct3",    32'(funct3), 32'd0);

        // decode stall
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
            chk("stall_valid",  32'(instr_valid), 32'd1);
            @(negedge clk);
        end
        consume(1'b0, $urandom);
        wait_req("seq_req");
        chk("seq_addr", imem_addr, 32'h4);

        // taken redirect
        wait_valid("seq_valid");
        consume(1'b1, 32'h40);
        wait_req("redir_req");
        chk("redir_addr", imem_addr, 32'h40);
        wait_valid("redir_valid");
        chk("redir_pc", PC, 32'h40);

        // slow memory with spurious responses while requesting
        ready_pct = 0; spurious_en = 1;
        consume(1'b0, $urandom);
        wait_req("slow_req");
        for (int i = 0; i < 4; i++) begin
            chk("slow_req_held", 32'(imem_req_valid), 32'd1);
            @(negedge clk);
        end
        rsp_min = 3; rsp_max = 3; ready_pct = 100;
        wait_valid("slow_valid");
        chk("slow_pc", PC, 32'h44);
        spurious_en = 0;

        // reset while waiting, stale response arrives afterwards
        consume(1'b0, $urandom);
        wait_req("rstwait_req");
        @(posedge clk);
        #1 rst = 1'b1;
        rsp_min = 0; rsp_max = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstwait_valid", 32'(instr_valid), 32'd0);
        chk("rstwait_instr", Instr, NOP);
        chk("rstwait_pc",    PC, 32'h0);
        wait_valid("rstwait_refetch");
        chk("rstwait_word",  Instr, WORD0);
        chk("rstwait_pc0",   PC, 32'h0);

        // PC + 4 wraps
        consume(1'b1, 32'hFFFF_FFFC);
        wait_valid("wrap_valid");
        chk("wrap_pc",      PC, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        consume(1'b0, $urandom);
        wait_req("wrap_req");
        chk("wrap_addr", imem_addr, 32'h0);
        wait_valid("wrap_refetch");

        // misaligned redirect
        consume(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_no_req", 32'(imem_req_valid), 32'd0);
        wait_valid("trap_valid");
        chk("trap_fault", 32'(fetch_fault), 32'd1);
        chk("trap_pc",    PC, 32'h42);
        chk("trap_instr", Instr, NOP);
        @(negedge clk);
        chk("trap_still_no_req", 32'(imem_req_valid), 32'd0);
        consume(1'b0, $urandom);
        wait_req("trap_next_req");
        chk("trap_next_addr", imem_addr, 32'h44);
        wait_valid("trap_next_valid");
        chk("trap_cleared", 32'(fetch_fault), 32'd0);
`else
        wait_req("mis_req");
        chk("mis_addr", imem_addr, 32'h40);
        wait_valid("mis_valid");
        chk("mis_pc", PC, 32'h40);
`endif

        // randomized traffic with periodic resets
        ready_pct = 70; rsp_min = 0; rsp_max = 3;
        cons_pct = 60; redir_pct = 25; spurious_en = 1;
        auto_cons = 1;
        for (int r = 0; r < 4; r++) begin
            repeat (500) @(negedge clk);
            do_reset(2);
        end
        auto_cons = 0;
        instr_ready = 0; pcSrc = 0; spurious_en = 0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
